cmd_saver: RTL

// - Upload-side counterpart of the CMD loader: reads a TRS-80 RAM range and emits it as a /CMD byte stream.
// - Output is a valid/ready byte stream toward the HPS upload path (save program to SD).
// - Records: type 01 load blocks (len, addr lo, addr hi, data), then a type 02 transfer record.
// - Sits beside cmd_loader on the shared dn_* RAM port; arbitration is external.

---
 rtl/cmd_saver.sv | 350 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_saver.sv
// cmd_saver: reads a TRS-80 RAM range and emits it as a /CMD byte stream.
//
// Stream layout:
//   [optional name header: 05 06 c0 c1 c2 c3 c4 c5]
//   type 01 load records: 01, (n+2)[7:0], addr lo, addr hi, n data bytes
//   type 02 transfer record: 02 02 exec lo exec hi
//
// Optional feature macro: CMD_NAME_HDR_EN
//   Adds the name[47:0] input (char0 in [7:0]) and the HDR state.
//
// Ports:
//   clock, reset_n              system clock, async active-low reset
//   start, start_addr, end_addr,
//   exec_addr                   save request; sampled only when idle
//   mem_addr, mem_rd, mem_din   shared RAM read port (data RAM_LAT clocks after mem_rd)
//   out_data/out_valid/out_ready  valid/ready byte stream to the upload path
//   busy, done, error           status (error sticky until next accepted start)
//   byte_count                  bytes accepted in the current save
module cmd_saver #(
  parameter int BLK_MAX = 256,
  parameter int RAM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] exec_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [16:0] byte_count
`ifdef CMD_NAME_HDR_EN
  ,
  input  logic [47:0] name
`endif
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    BTYPE = 4'd1,
    BLEN  = 4'd2,
    BALO  = 4'd3,
    BAHI  = 4'd4,
    RD    = 4'd5,
    RWAIT = 4'd6,
    DATA  = 4'd7,
    XTYPE = 4'd8,
    XLEN  = 4'd9,
    XLO   = 4'd10,
    XHI   = 4'd11,
    FIN   = 4'd12
`ifdef CMD_NAME_HDR_EN
    ,
    HDR   = 4'd13
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        rst_n_s;
  // cur/end are 17 bits so that end_addr=0xFFFF terminates instead of wrapping
  logic [16:0] cur_q, cur_d;
  logic [16:0] end_q, end_d;
  logic [15:0] exec_q, exec_d;
  logic [8:0]  blk_rem_q, blk_rem_d;   // reads still to issue in current block
  logic [2:0]  wait_q, wait_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [16:0] byte_count_q, byte_count_d;
  logic        hs_s;
  logic        rd_issue_s;
  logic [16:0] rem_s;
  logic [8:0]  n_s;
  logic [7:0]  len_s;
`ifdef CMD_NAME_HDR_EN
  logic [47:0] name_q, name_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;

  // Header byte idx: record type/length, then the six name characters
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [47:0] nm);
    case (idx)
      3'd0:    hdr_byte = 8'h05;
      3'd1:    hdr_byte = 8'h06;
      3'd2:    hdr_byte = nm[7:0];
      3'd3:    hdr_byte = nm[15:8];
      3'd4:    hdr_byte = nm[23:16];
      3'd5:    hdr_byte = nm[31:24];
      3'd6:    hdr_byte = nm[39:32];
      3'd7:    hdr_byte = nm[47:40];
      default: hdr_byte = 8'h00;
    endcase
  endfunction
`endif

  assign hs_s  = out_valid_q & out_ready;
  assign rem_s = end_q - cur_q + 17'd1;
  assign n_s   = (rem_s > 17'(BLK_MAX)) ? 9'(BLK_MAX) : rem_s[8:0];
  // Length byte counts the two address bytes; n=256 wraps to 0x02
  assign len_s = n_s[7:0] + 8'd2;

  // mem_rd is decoded from state and the handshake so the next read can
  // issue in the very clock a data byte is accepted (one byte per RAM_LAT+1)
  assign mem_rd     = rd_issue_s;
  assign mem_addr   = cur_q[15:0];
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = byte_count_q;
  assign rst_n_s    = rst_sync_q[1];

  // Reset synchronizer: asserts immediately, releases two clocks later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q      <= IDLE;
      cur_q        <= 17'd0;
      end_q        <= 17'd0;
      exec_q       <= 16'd0;
      blk_rem_q    <= 9'd0;
      wait_q       <= 3'd0;
      out_data_q   <= 8'd0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_count_q <= 17'd0;
`ifdef CMD_NAME_HDR_EN
      name_q       <= 48'd0;
      hdr_idx_q    <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      exec_q       <= exec_d;
      blk_rem_q    <= blk_rem_d;
      wait_q       <= wait_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      byte_count_q <= byte_count_d;
`ifdef CMD_NAME_HDR_EN
      name_q       <= name_d;
      hdr_idx_q    <= hdr_idx_d;
`endif
    end
  end

  // Next-state logic: each byte state holds its byte until the handshake,
  // then loads the following byte in the same clock
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    exec_d       = exec_q;
    blk_rem_d    = blk_rem_q;
    wait_d       = wait_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    byte_count_d = byte_count_q + {16'd0, hs_s};
    rd_issue_s   = 1'b0;
`ifdef CMD_NAME_HDR_EN
    name_d       = name_q;
    hdr_idx_d    = hdr_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d        = {1'b0, start_addr};
          end_d        = {1'b0, end_addr};
          exec_d       = exec_addr;
          byte_count_d = 17'd0;
          error_d      = 1'b0;
          if (end_addr < start_addr) begin
            // Empty range: flag and finish without ever going busy
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
`ifdef CMD_NAME_HDR_EN
            name_d      = name;
            hdr_idx_d   = 3'd0;
            out_data_d  = 8'h05;
            state_d     = HDR;
`else
            out_data_d  = 8'h01;
            state_d     = BTYPE;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef CMD_NAME_HDR_EN
      HDR: begin
        if (hs_s) begin
          if (hdr_idx_q == 3'd7) begin
            out_data_d = 8'h01;
            state_d    = BTYPE;
          end else begin
            hdr_idx_d  = hdr_idx_q + 3'd1;
            out_data_d = hdr_byte(hdr_idx_q + 3'd1, name_q);
          end
        end else begin
          state_d = HDR;
        end
      end
`endif
      BTYPE: begin
        if (hs_s) begin
          out_data_d = len_s;
          blk_rem_d  = n_s;
          state_d    = BLEN;
        end else begin
          state_d = BTYPE;
        end
      end
      BLEN: begin
        if (hs_s) begin
          out_data_d = cur_q[7:0];
          state_d    = BALO;
        end else begin
          state_d = BLEN;
        end
      end
      BALO: begin
        if (hs_s) begin
          out_data_d = cur_q[15:8];
          state_d    = BAHI;
        end else begin
          state_d = BALO;
        end
      end
      BAHI: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          state_d     = RD;
        end else begin
          state_d = BAHI;
        end
      end
      RD: begin
        rd_issue_s = 1'b1;
        cur_d      = cur_q + 17'd1;
        blk_rem_d  = blk_rem_q - 9'd1;
        wait_d     = 3'd1;
        state_d    = RWAIT;
      end
      RWAIT: begin
        if (wait_q == 3'(RAM_LAT)) begin
          out_data_d  = mem_din;
          out_valid_d = 1'b1;
          state_d     = DATA;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      DATA: begin
        if (hs_s) begin
          if (blk_rem_q != 9'd0) begin
            // Overlap the next read with this handshake
            rd_issue_s  = 1'b1;
            cur_d       = cur_q + 17'd1;
            blk_rem_d   = blk_rem_q - 9'd1;
            wait_d      = 3'd1;
            out_valid_d = 1'b0;
            state_d     = RWAIT;
          end else if (cur_q > end_q) begin
            out_data_d = 8'h02;
            state_d    = XTYPE;
          end else begin
            out_data_d = 8'h01;
            state_d    = BTYPE;
          end
        end else begin
          state_d = DATA;
        end
      end
      XTYPE: begin
        if (hs_s) begin
          out_data_d = 8'h02;
          state_d    = XLEN;
        end else begin
          state_d = XTYPE;
        end
      end
      XLEN: begin
        if (hs_s) begin
          out_data_d = exec_q[7:0];
          state_d    = XLO;
        end else begin
          state_d = XLEN;
        end
      end
      XLO: begin
        if (hs_s) begin
          out_data_d = exec_q[15:8];
          state_d    = XHI;
        end else begin
          state_d = XLO;
        end
      end
      XHI: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          state_d     = FIN;
        end else begin
          state_d = XHI;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

endmodule
